// File: rtl/ndata_widener_if.sv
// Normalized lane stream: valid/ready handshake with
// per-lane keep and an end-of-stream marker.
interface ndata_i #(
  parameter type data_t = logic [7:0],
  parameter int NUM_ELEMENTS = 1
);
  logic                    valid;
  logic                    ready;
  logic                    last;
  data_t [NUM_ELEMENTS-1:0] data;
  logic [NUM_ELEMENTS-1:0] keep;

  modport m (
    output valid, data, keep, last,
    input  ready
  );

  modport s (
    input  valid, data, keep, last,
    output ready
  );
endinterface

// File: rtl/ndata_widener.sv
// Packs RATIO consecutive normalized beats into one
// wide beat; a last beat closes the wide beat early.
module ndata_widener #(
  parameter type data_t = logic [7:0],
  parameter int NUM_ELEMENTS = 4,
  parameter int RATIO = 2
) (
  input  logic clk,
  input  logic rst,
  ndata_i.s    in,
  ndata_i.m    out,
  output logic err
);
  localparam int NE = NUM_ELEMENTS;
  localparam int W  = NE * RATIO;
  localparam int IW = $clog2(RATIO);
  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

  data_t [RATIO-2:0][NE-1:0] slot_data;
  logic  [RATIO-2:0][NE-1:0] slot_keep;
  logic  [IW-1:0]            idx;

  data_t [W-1:0] wide_data;
  data_t [W-1:0] out_data;
  logic  [W-1:0] wide_keep;
  logic  [W-1:0] out_keep;
  logic          out_valid;
  logic          out_last;
  logic          accept;
  logic          complete;
  logic          bad_keep;

  assign in.ready = !out_valid || out.ready;
  assign accept   = in.valid && in.ready;
  assign complete = accept &&
                    (idx == LAST_IDX || in.last);

  // keep & (keep+1) is zero only for a 0..01..1 prefix
  assign bad_keep = in.last
    ? |(in.keep & (in.keep + 1'b1))
    : !(&in.keep);

  for (genvar k = 0; k < RATIO; k++) begin : g_slot
    localparam logic [IW-1:0] KI = IW'(k);
    if (k < RATIO - 1) begin : g_buf
      assign wide_data[k*NE +: NE] =
        (KI == idx) ? in.data : slot_data[k];
      assign wide_keep[k*NE +: NE] =
        (KI == idx) ? in.keep :
        (KI <  idx) ? slot_keep[k] : '0;
    end else begin : g_top
      assign wide_data[k*NE +: NE] = in.data;
      assign wide_keep[k*NE +: NE] =
        (KI == idx) ? in.keep : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_keep  <= '0;
      idx       <= '0;
      err       <= 1'b0;
      slot_keep <= '0;
    end else begin
      if (out_valid && out.ready) begin
        out_valid <= 1'b0;
      end
      if (complete) begin
        out_valid <= 1'b1;
        out_keep  <= wide_keep;
        out_last  <= in.last;
        idx       <= '0;
      end else if (accept) begin
        slot_keep[idx] <= in.keep;
        idx            <= idx + 1'b1;
      end
      if (accept && bad_keep) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (complete) begin
      out_data <= wide_data;
    end else if (accept) begin
      slot_data[idx] <= in.data;
    end
  end

  assign out.valid = out_valid;
  assign out.last  = out_last;
  assign out.keep  = out_keep;
  assign out.data  = out_data;
endmodule

// File: tb/tb_ndata_widener.sv
// Bench for ndata_widener: directed scenarios on
// RATIO=2 and RATIO=4 instances plus a random scoreboard.
module tb_ndata_widener;
  typedef logic [7:0] byte_t;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } wbeat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err2;
  logic err4;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ndata_i #(.data_t(byte_t), .NUM_ELEMENTS(4))  i2 ();
  ndata_i #(.data_t(byte_t), .NUM_ELEMENTS(8))  o2 ();
  ndata_i #(.data_t(byte_t), .NUM_ELEMENTS(4))  i4 ();
  ndata_i #(.data_t(byte_t), .NUM_ELEMENTS(16)) o4 ();

  ndata_widener #(
    .data_t(byte_t), .NUM_ELEMENTS(4), .RATIO(2)
  ) u2 (
    .clk(clk), .rst(rst), .in(i2), .out(o2), .err(err2)
  );

  ndata_widener #(
    .data_t(byte_t), .NUM_ELEMENTS(4), .RATIO(4)
  ) u4 (
    .clk(clk), .rst(rst), .in(i4), .out(o4), .err(err4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic v, input logic l,
                        input logic [3:0] k,
                        input logic [31:0] d);
    i2.valid = v;
    i2.last  = l;
    i2.keep  = k;
    i2.data  = d;
  endtask

  task automatic drive4(input logic v, input logic l,
                        input logic [3:0] k,
                        input logic [31:0] d);
    i4.valid = v;
    i4.last  = l;
    i4.keep  = k;
    i4.data  = d;
  endtask

  function automatic logic [31:0] beat(input int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  function automatic logic [127:0] kmask(
    input logic [15:0] k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = {8{k[i]}};
    return r;
  endfunction

  task automatic chk4(input string nm,
                      input logic [127:0] ed,
                      input logic [15:0] ek,
                      input logic el);
    tests++;
    if (o4.valid !== 1'b1 || o4.keep !== ek ||
        o4.last !== el ||
        (o4.data & kmask(ek)) !== (ed & kmask(ek))) begin
      fails++;
      $display("FAIL %s: v=%b k=%h l=%b d=%h want k=%h l=%b d=%h",
               nm, o4.valid, o4.keep, o4.last,
               o4.data & kmask(ek), ek, el, ed & kmask(ek));
    end
  endtask

  task automatic test_reset();
    drive2(0, 0, 0, 0);
    drive4(0, 0, 0, 0);
    o2.ready = 1'b1;
    o4.ready = 1'b1;
    #2 rst = 1'b1;
    #20;
    tests++;
    if (o2.valid !== 1'b0 || o4.valid !== 1'b0 ||
        o4.keep !== 16'h0 || o4.last !== 1'b0 ||
        err2 !== 1'b0 || err4 !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: v2=%b v4=%b k=%h l=%b e=%b%b want 0",
               o2.valid, o4.valid, o4.keep, o4.last,
               err2, err4);
    end
    @(negedge clk) rst = 1'b0;
    step();
    tests++;
    if (i2.ready !== 1'b1 || i4.ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: r2=%b r4=%b want 1",
               i2.ready, i4.ready);
    end
  endtask

  task automatic test_full_packing();
    drive2(1, 0, 4'hF, beat(1));
    step();
    tests++;
    if (o2.valid !== 1'b0) begin
      fails++;
      $display("FAIL pack_gap0: v=%b want 0", o2.valid);
    end
    drive2(1, 0, 4'hF, beat(5));
    step();
    tests++;
    if (o2.valid !== 1'b1 || o2.keep !== 8'hFF ||
        o2.last !== 1'b0 ||
        o2.data !== {beat(5), beat(1)}) begin
      fails++;
      $display("FAIL pack_beat0: v=%b k=%h l=%b d=%h want 1 ff 0 %h",
               o2.valid, o2.keep, o2.last, o2.data,
               {beat(5), beat(1)});
    end
    drive2(1, 0, 4'hF, beat(9));
    step();
    tests++;
    if (o2.valid !== 1'b0) begin
      fails++;
      $display("FAIL pack_gap1: v=%b want 0", o2.valid);
    end
    drive2(1, 1, 4'hF, beat(13));
    step();
    tests++;
    if (o2.valid !== 1'b1 || o2.keep !== 8'hFF ||
        o2.last !== 1'b1 ||
        o2.data !== {beat(13), beat(9)}) begin
      fails++;
      $display("FAIL pack_beat1: v=%b k=%h l=%b d=%h want 1 ff 1 %h",
               o2.valid, o2.keep, o2.last, o2.data,
               {beat(13), beat(9)});
    end
    drive2(0, 0, 0, 0);
    step();
    tests++;
    if (o2.valid !== 1'b0) begin
      fails++;
      $display("FAIL pack_idle: v=%b want 0", o2.valid);
    end
  endtask

  task automatic test_partial_last();
    for (int b = 0; b < 3; b++) begin
      drive4(1, 0, 4'hF, beat(1 + 4 * b));
      step();
      tests++;
      if (o4.valid !== 1'b0) begin
        fails++;
        $display("FAIL partial_early_valid: beat %0d v=%b want 0",
                 b, o4.valid);
      end
    end
    drive4(1, 1, 4'b0011, beat(13));
    step();
    chk4("partial_last", {beat(13), beat(9), beat(5), beat(1)},
         16'h3FFF, 1'b1);
  endtask

  task automatic test_early_last();
    drive4(1, 1, 4'b0111, beat(40));
    step();
    chk4("early_last", 128'(beat(40)), 16'h0007, 1'b1);
    drive4(0, 0, 0, 0);
    step();
  endtask

  task automatic test_empty_last();
    drive4(1, 1, 4'b0000, beat(0));
    step();
    chk4("empty_last_idx0", '0, 16'h0000, 1'b1);
    drive4(1, 0, 4'hF, beat(50));
    step();
    drive4(1, 1, 4'b0000, beat(0));
    step();
    chk4("empty_last_mid", 128'(beat(50)), 16'h000F, 1'b1);
    drive4(0, 0, 0, 0);
    step();
  endtask

  task automatic test_backpressure();
    o4.ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive4(1, b == 3, 4'hF, beat(60 + 4 * b));
      step();
    end
    drive4(1, 0, 4'hF, beat(80));
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (i4.ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_ready: cycle %0d r=%b want 0",
                 c, i4.ready);
      end
      chk4("stall_hold",
           {beat(72), beat(68), beat(64), beat(60)},
           16'hFFFF, 1'b1);
      step();
    end
  endtask

  task automatic test_back_to_back();
    o4.ready = 1'b1;
    step();
    tests++;
    if (o4.valid !== 1'b0) begin
      fails++;
      $display("FAIL release_drain: v=%b want 0", o4.valid);
    end
    drive4(1, 0, 4'hF, beat(84));
    step();
    drive4(1, 0, 4'hF, beat(88));
    step();
    drive4(1, 0, 4'hF, beat(92));
    step();
    chk4("release_next",
         {beat(92), beat(88), beat(84), beat(80)},
         16'hFFFF, 1'b0);
    drive4(1, 1, 4'b0001, beat(100));
    step();
    chk4("drain_and_last", 128'(beat(100)), 16'h0001, 1'b1);
    drive4(0, 0, 0, 0);
    step();
    tests++;
    if (o4.valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: v=%b want 0", o4.valid);
    end
  endtask

  task automatic test_random();
    wbeat_t       exp_q[$];
    logic [31:0]  gd[$];
    logic [3:0]   gk[$];
    wbeat_t       e;
    logic         pend = 1'b0;
    logic         bl = 1'b0;
    logic [3:0]   bk = '0;
    logic [31:0]  bd = '0;
    logic         ain;
    logic         aout;
    logic [127:0] od;
    logic [15:0]  ok;
    logic         ol;
    int           n = 0;
    int           cyc = 0;
    int           drain = 0;
    while ((n < 1000 && cyc < 20000) || drain < 6) begin
      if (n >= 1000 || cyc >= 20000) begin
        pend = 1'b0;
        drain++;
      end else if (!pend && ($urandom % 4) != 0) begin
        pend = 1'b1;
        bl   = ($urandom % 5) == 0;
        bk   = bl ? 4'((1 << ($urandom % 5)) - 1) : 4'hF;
        bd   = $urandom;
      end
      drive4(pend, bl, bk, bd);
      o4.ready = (drain > 0) || (($urandom % 3) != 0);
      #1;
      ain  = i4.valid && i4.ready;
      aout = o4.valid && o4.ready;
      od   = o4.data;
      ok   = o4.keep;
      ol   = o4.last;
      step();
      cyc++;
      if (aout) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rand_extra: k=%h l=%b want none", ok, ol);
        end else begin
          e = exp_q.pop_front();
          if (ok !== e.k || ol !== e.l ||
              (od & kmask(e.k)) !== (e.d & kmask(e.k))) begin
            fails++;
            $display("FAIL rand_beat: k=%h l=%b d=%h want k=%h l=%b d=%h",
                     ok, ol, od & kmask(e.k), e.k, e.l,
                     e.d & kmask(e.k));
          end
        end
      end
      if (ain) begin
        gd.push_back(bd);
        gk.push_back(bk);
        if (gd.size() == 4 || bl) begin
          e.d = '0;
          e.k = '0;
          e.l = bl;
          for (int i = 0; i < gd.size(); i++) begin
            e.d[i*32 +: 32] = gd[i];
            e.k[i*4 +: 4]   = gk[i];
          end
          exp_q.push_back(e);
          gd.delete();
          gk.delete();
        end
        pend = 1'b0;
        n++;
      end
    end
    tests++;
    if (n < 1000 || exp_q.size() != 0 || err4 !== 1'b0) begin
      fails++;
      $display("FAIL rand_end: beats=%0d left=%0d err=%b want 1000 0 0",
               n, exp_q.size(), err4);
    end
    drive4(0, 0, 0, 0);
  endtask

  task automatic test_error_reset();
    o4.ready = 1'b1;
    drive4(1, 0, 4'b1011, beat(110));
    step();
    tests++;
    if (err4 !== 1'b1) begin
      fails++;
      $display("FAIL err_set: err=%b want 1", err4);
    end
    drive4(1, 0, 4'hF, beat(114));
    step();
    drive4(0, 0, 0, 0);
    step();
    step();
    tests++;
    if (err4 !== 1'b1 || o4.valid !== 1'b0) begin
      fails++;
      $display("FAIL err_sticky: err=%b v=%b want 1 0",
               err4, o4.valid);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (err4 !== 1'b0 || u4.idx !== 2'd0 ||
        o4.valid !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_mid: err=%b idx=%0d v=%b want 0 0 0",
               err4, u4.idx, o4.valid);
    end
    @(negedge clk) rst = 1'b0;
    step();
    drive4(1, 1, 4'b0011, beat(130));
    step();
    chk4("post_rst_stream", 128'(beat(130)), 16'h0003, 1'b1);
    o4.ready = 1'b0;
    drive4(0, 0, 0, 0);
    step();
    #2 rst = 1'b1;
    #1;
    tests++;
    if (o4.valid !== 1'b0 || o4.keep !== 16'h0 ||
        o4.last !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_out: v=%b k=%h l=%b want 0 0 0",
               o4.valid, o4.keep, o4.last);
    end
    @(negedge clk) rst = 1'b0;
    o4.ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_full_packing();
    test_partial_last();
    test_early_last();
    test_empty_last();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_error_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
